// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32 access-size codes, FSM states
// and the byte-enable helper.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACCESS    = 3'd1,
    ST_ACCESS_LO = 3'd2,
    ST_ACCESS_HI = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Lower nibble: lanes of the addressed word; upper nibble: lanes that spill
  // into the following word (only non-zero for a word-crossing access).
  function automatic logic [7:0] be_for(input logic [2:0] size, input logic [1:0] offset);
    logic [7:0] base;
    case (size[1:0])
      2'b00:   base = 8'b0000_0001;
      2'b01:   base = 8'b0000_0011;
      2'b10:   base = 8'b0000_1111;
      default: base = 8'b0000_0000;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/halfword lane at the given offset and
// sign- or zero-extends it according to funct3; words pass through.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  assign lane = word >> {offset, 3'b000};

  always_comb begin
    data = lane;
    case (funct3)
      MEM_B:   data = {{24{lane[7]}}, lane[7:0]};
      MEM_BU:  data = {24'h0, lane[7:0]};
      MEM_H:   data = {{16{lane[15]}}, lane[15:0]};
      MEM_HU:  data = {16'h0, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Load/store unit: req/resp handshake to the core, strobe/ready protocol to a word RAM.
// Define MEM_UNIT_MISALIGNED_EN to split word-crossing H/W accesses into two RAM words.
//
// Handshakes: a request is taken on a clock edge where req_valid && req_ready;
// req_ready is high only in IDLE and the core holds req_valid until taken.
// ram_re/ram_we stay high with stable ram_addr/ram_be/ram_wdata until the edge
// where ram_ready is high. resp_valid is a single-cycle pulse, resp_err qualifies it.
module mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready,
  output logic [2:0]        dbg_state
);

  state_t            state, state_d;
  logic [ADDR_W-3:0] word_addr_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic              err_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       timer_q;

  logic [1:0]        req_off;
  logic              size_ok;
  logic              req_bad;
  logic              need_split;
  logic              expire;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata_sh;
  logic [31:0]       ext_word;
  logic [1:0]        ext_off;
  logic [31:0]       ext_data;

  assign req_off      = req_addr[1:0];
  assign req_wdata_sh = req_wdata << {req_off, 3'b000};

  always_comb begin
    size_ok = 1'b0;
    case (req_funct3)
      MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: size_ok = 1'b1;
      default:                             size_ok = 1'b0;
    endcase
  end

`ifdef MEM_UNIT_MISALIGNED_EN
  logic [3:0]  req_be_hi;
  logic [31:0] req_wdata_hi;
  logic [3:0]  be_hi_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] lo_word_q;

  assign {req_be_hi, req_be} = be_for(req_funct3, req_off);
  // Bytes shifted out of the low word land at the bottom of the next word.
  assign req_wdata_hi = req_wdata >> (6'd32 - {1'b0, req_off, 3'b000});
  assign req_bad      = !size_ok;
  assign need_split   = |req_be_hi;

  // The high-half read completes the merge: realign the 64-bit pair, extend from lane 0.
  assign ext_word = (state == ST_ACCESS_HI) ? 32'({ram_rdata, lo_word_q} >> {off_q, 3'b000})
                                            : ram_rdata;
  assign ext_off  = (state == ST_ACCESS_HI) ? 2'b00 : off_q;
`else
  logic misaligned;

  assign req_be     = 4'(be_for(req_funct3, req_off));
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
  assign req_bad    = !size_ok || misaligned;
  assign need_split = 1'b0;
  assign ext_word   = ram_rdata;
  assign ext_off    = off_q;
`endif

  assign expire = (TIMEOUT != 0) && (timer_q == 32'(TIMEOUT - 1));

  load_align u_load_align (
    .word   (ext_word),
    .offset (ext_off),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_be     = 4'b0000;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)         state_d = ST_RESP;
          else if (need_split) state_d = ST_ACCESS_LO;
          else                 state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_re = !we_q;
        ram_we = we_q;
        ram_be = be_q;
        // Completion takes priority over a timeout expiring in the same cycle.
        if (ram_ready || expire) state_d = ST_RESP;
      end
`ifdef MEM_UNIT_MISALIGNED_EN
      ST_ACCESS_LO: begin
        ram_re = !we_q;
        ram_we = we_q;
        ram_be = be_q;
        if (ram_ready)   state_d = ST_ACCESS_HI;
        else if (expire) state_d = ST_RESP;
      end
      ST_ACCESS_HI: begin
        ram_re = !we_q;
        ram_we = we_q;
        ram_be = be_hi_q;
        if (ram_ready || expire) state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_addr_q <= '0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      timer_q     <= 32'h0;
`ifdef MEM_UNIT_MISALIGNED_EN
      be_hi_q     <= 4'b0000;
      wdata_hi_q  <= 32'h0;
      lo_word_q   <= 32'h0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            word_addr_q <= req_addr[ADDR_W-1:2];
            off_q       <= req_off;
            funct3_q    <= req_funct3;
            we_q        <= req_we;
            be_q        <= req_be;
            wdata_q     <= req_wdata_sh;
            err_q       <= req_bad;
            rdata_q     <= 32'h0;
            timer_q     <= 32'h0;
`ifdef MEM_UNIT_MISALIGNED_EN
            be_hi_q     <= req_be_hi;
            wdata_hi_q  <= req_wdata_hi;
`endif
          end
        end
`ifdef MEM_UNIT_MISALIGNED_EN
        ST_ACCESS_LO: begin
          if (ram_ready) begin
            lo_word_q   <= ram_rdata;
            // Wraps modulo the word-address space at the top of memory.
            word_addr_q <= word_addr_q + (ADDR_W-2)'(1);
            wdata_q     <= wdata_hi_q;
            timer_q     <= 32'h0;
          end else if (expire) begin
            err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        ST_ACCESS_HI: begin
          if (ram_ready) begin
            if (!we_q) rdata_q <= ext_data;
          end else if (expire) begin
            err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
`endif
        ST_ACCESS: begin
          if (ram_ready) begin
            if (!we_q) rdata_q <= ext_data;
          end else if (expire) begin
            err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr   = word_addr_q;
  assign ram_wdata  = wdata_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: a wait-state RAM responder, a request driver and a
// response monitor fed from an expected-response queue.
module tb_mem_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-3:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              ram_re;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              ram_ready;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  mem_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Entry: {latency[7:0] (0 = unchecked), err, rdata[31:0]}
  logic [40:0] exp_q[$];
  int          acc_q[$];

  logic [31:0] mem [int];
  int          wait_cycles = 0;
  bit          never_ready = 1'b0;
  int          re_cycles   = 0;
  int          we_cycles   = 0;
  int          strobe_cnt  = 0;
  logic [29:0] log_addr[$];
  logic [3:0]  log_be[$];
  logic [31:0] log_wd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM responder: completes a strobe after wait_cycles stalled cycles.
  initial begin
    logic        pend;
    logic [29:0] p_addr;
    logic [3:0]  p_be;
    logic [31:0] p_wd;
    logic [31:0] w;
    pend      = 1'b0;
    p_addr    = '0;
    p_be      = '0;
    p_wd      = '0;
    ram_ready = 1'b0;
    ram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (ram_re || ram_we) begin
        if (ram_re) re_cycles++;
        if (ram_we) we_cycles++;
        if (pend) begin
          check("ram_addr_stable", 32'(ram_addr), 32'(p_addr));
          check("ram_be_stable", 32'(ram_be), 32'(p_be));
          check("ram_wdata_stable", ram_wdata, p_wd);
        end
        strobe_cnt++;
        if (!never_ready && strobe_cnt > wait_cycles) begin
          w = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
          ram_ready = 1'b1;
          ram_rdata = w;
          if (ram_we) begin
            for (int i = 0; i < 4; i++)
              if (ram_be[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
            mem[int'(ram_addr)] = w;
          end
          log_addr.push_back(ram_addr);
          log_be.push_back(ram_be);
          log_wd.push_back(ram_wdata);
          strobe_cnt = 0;
          pend       = 1'b0;
        end else begin
          ram_ready = 1'b0;
          ram_rdata = 32'hDEAD_BEEF;
          pend      = 1'b1;
          p_addr    = ram_addr;
          p_be      = ram_be;
          p_wd      = ram_wdata;
        end
      end else begin
        ram_ready  = 1'b0;
        ram_rdata  = 32'h0;
        strobe_cnt = 0;
        pend       = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    logic [40:0] e;
    int          a;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual resp_valid=1 required=0 (err=%0b rdata=%h)", resp_err, resp_rdata);
        end else begin
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : 0;
          check("resp_err", 32'(resp_err), 32'(e[32]));
          check("resp_rdata", resp_rdata, e[31:0]);
          if (e[40:33] != 8'd0) check("resp_latency", 32'(cyc - a), 32'(e[40:33]));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                       input int elat);
    int n;
    logic [7:0] lat8;
    lat8 = 8'(elat);
    re_cycles = 0;
    we_cycles = 0;
    log_addr.delete();
    log_be.delete();
    log_wd.delete();
    exp_q.push_back({lat8, eerr, erd});
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_accepted", 32'(req_ready), 32'd1);
    acc_q.push_back(cyc);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrived", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
  endtask

  task automatic expect_ram(input int nre, input int nwe, input int idx,
                            input logic [29:0] a, input logic [3:0] be, input logic [31:0] wd);
    check("re_cycles", 32'(re_cycles), 32'(nre));
    check("we_cycles", 32'(we_cycles), 32'(nwe));
    if (idx >= 0) begin
      check("ram_log_len", 32'(log_addr.size() > idx), 32'd1);
      if (log_addr.size() > idx) begin
        check("ram_addr", 32'(log_addr[idx]), 32'(a));
        check("ram_be", 32'(log_be[idx]), 32'(be));
        if (nwe != 0) check("ram_wdata", log_wd[idx], wd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem[32'h40] = 32'h80FF_1234;
    mem[32'h04] = 32'h1234_5678;
    mem[32'h01] = 32'hAA00_0000;
    mem[32'h02] = 32'h0000_00BB;

    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_ram_re", 32'(ram_re), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Loads from word 0x40 = 0x80FF_1234, zero wait states.
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 2);
    expect_ram(1, 0, 0, 30'h40, 4'b1000, 32'h0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0000_0080, 2);
    issue(1'b0, 3'b000, 32'h101, 32'h0, 1'b0, 32'h0000_0012, 2);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'hFFFF_80FF, 2);
    issue(1'b0, 3'b101, 32'h100, 32'h0, 1'b0, 32'h0000_1234, 2);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h80FF_1234, 2);

    // Store halfword with three wait states, then read it back.
    wait_cycles = 3;
    issue(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 1'b0, 32'h0, 5);
    expect_ram(0, 4, 0, 30'h8, 4'b1100, 32'hABCD_0000);
    wait_cycles = 0;
    issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF_ABCD, 2);
    issue(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h0000_ABCD, 2);

    // Byte and word stores.
    issue(1'b1, 3'b000, 32'h41, 32'h0000_01FF, 1'b0, 32'h0, 2);
    expect_ram(0, 1, 0, 30'h10, 4'b0010, 32'h0001_FF00);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h0000_FF00, 2);
    issue(1'b1, 3'b010, 32'h44, 32'hCAFE_F00D, 1'b0, 32'h0, 2);
    expect_ram(0, 1, 0, 30'h11, 4'b1111, 32'hCAFE_F00D);
    issue(1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 32'hCAFE_F00D, 2);

    // Illegal funct3 never touches the RAM.
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 1);
    expect_ram(0, 0, -1, 30'h0, 4'b0, 32'h0);
    issue(1'b1, 3'b110, 32'h4, 32'h1, 1'b1, 32'h0, 1);
    expect_ram(0, 0, -1, 30'h0, 4'b0, 32'h0);

`ifdef MEM_UNIT_MISALIGNED_EN
    // Word-crossing halfword: two reads merged.
    issue(1'b0, 3'b101, 32'h7, 32'h0, 1'b0, 32'h0000_BBAA, 3);
    expect_ram(2, 0, 0, 30'h1, 4'b1000, 32'h0);
    expect_ram(2, 0, 1, 30'h2, 4'b0001, 32'h0);
`else
    // Misaligned accesses are rejected without a strobe.
    issue(1'b0, 3'b010, 32'h5, 32'h0, 1'b1, 32'h0, 1);
    expect_ram(0, 0, -1, 30'h0, 4'b0, 32'h0);
    issue(1'b0, 3'b001, 32'h3, 32'h0, 1'b1, 32'h0, 1);
    expect_ram(0, 0, -1, 30'h0, 4'b0, 32'h0);
`endif

    // Timeout after four stalled cycles; ready on the fourth cycle wins.
    never_ready = 1'b1;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h0, 5);
    expect_ram(4, 0, -1, 30'h0, 4'b0, 32'h0);
    never_ready = 1'b0;
    wait_cycles = 3;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234_5678, 5);
    expect_ram(4, 0, 0, 30'h4, 4'b1111, 32'h0);
    wait_cycles = 0;

    // Reset in the middle of an access: outputs clear at once, no response.
    never_ready = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ram_re", 32'(ram_re), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ram_re", 32'(ram_re), 32'd0);
    check("mid_rst_ram_be", 32'(ram_be), 32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    never_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'd0);

    // Normal operation resumes after the abandoned access.
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234_5678, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Load/store unit between the multicycle core's control/datapath and a word-organised RAM.
- Replaces the current direct word-only RAM wiring with a req/resp handshake and RAM wait-state support.
- Generalises accesses to RV32 byte, halfword and word sizes with byte enables and sign/zero extension.
- Single outstanding request; the control FSM stalls the step counter until resp_valid.

Parameters:
- ADDR_W, 32, byte-address width seen by the core; RAM word address is ADDR_W-2 bits.
- TIMEOUT, 0, max cycles waiting for ram_ready before an error response; 0 = never time out.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, illegal funct3, or timeout
- ram_addr  out  ADDR_W-2  word address
- ram_wdata  out  32  lane-shifted store data
- ram_be  out  4  byte enables, bit i = byte i (little-endian)
- ram_re  out  1  read strobe
- ram_we  out  1  write strobe
- ram_rdata  in  32  read word, valid in the cycle ram_ready is high
- ram_ready  in  1  RAM completes the current strobe this cycle

Behaviour:
- Reset, asynchronous: state = IDLE. req_ready = 1. resp_valid, resp_err, ram_re, ram_we = 0. ram_be = 0. ram_addr, ram_wdata, resp_rdata = 0. Timeout counter = 0.
- A request mid-access is abandoned on reset; no response is issued.
- IDLE -> ACCESS on req_valid && req_ready:
  - Register addr, funct3, we and wdata.
  - Compute ram_be: B = 0001 << a[1:0]. H = 0011 << a[1:0]. W = 1111.
  - ram_wdata = wdata << (8*a[1:0]).
- Error check in IDLE at acceptance:
  - Misaligned (H with a[0] = 1, W with a[1:0] != 0) or illegal funct3 -> state RESP with err = 1.
  - No RAM strobe is asserted.
- ACCESS:
  - Assert ram_re or ram_we with registered ram_addr/ram_be; hold them stable until ram_ready.
  - On ram_ready: capture extended data -> RESP.
  - Minimum latency: accept at cycle 0, strobe cycles 1..n, resp_valid at cycle n+1. Zero-wait RAM gives resp_valid 2 cycles after acceptance.
- Timeout: counter increments each ACCESS cycle without ram_ready.
  - Reaching TIMEOUT drops the strobe -> RESP with err = 1.
  - ram_ready in the same cycle as expiry wins (normal completion).
- Load extension: select the lane byte/halfword by a[1:0].
  - B and H sign-extend from the top bit of the lane; BU and HU zero-extend; W passes through.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready = 0 in RESP, so back-to-back accesses have a 1-cycle gap.
- req_valid while req_ready = 0 is ignored; the core must hold it.

Optional Feature:
- Macro: MEM_UNIT_MISALIGNED_EN.
- With the macro defined: a misaligned H or W is split into two word accesses, low word then high word (addr+1).
  - States ACCESS_LO and ACCESS_HI. Byte enables and shifted data are split across both words; the two read words are merged before extension.
  - resp_err stays 0 unless a timeout occurs in either half.
  - A word address wrapping at the top of the address space wraps modulo 2^(ADDR_W-2).
- Without the macro: misaligned accesses produce the error response described above.

Decomposition:
- Package mem_pkg holds:
  - funct3 size constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
  - FSM state enum
  - function be_for(size, offset)
- Sub-module load_align: combinational lane select plus sign/zero extension. Reused by the split path for the merged word.

Test Plan:
- Zero-wait LB at addr 0x103, RAM word 0x80FF_1234 -> ram_be unused (read); resp_rdata 0xFFFF_FF80, resp_valid 2 cycles after accept.
- SH wdata 0x0000_ABCD at addr 0x22, ram_ready after 3 wait cycles -> ram_addr 0x8, ram_be 1100, ram_wdata 0xABCD_0000 held 4 cycles; resp_err 0.
- LW at addr 0x5, macro off -> no ram_re ever; resp_valid with resp_err 1, resp_rdata 0.
- TIMEOUT = 4, ram_ready never asserted -> ram_re high for 4 cycles, then resp_err 1. ram_ready on the 4th cycle instead -> normal data, err 0.
- Assert rst during ACCESS -> all outputs 0 immediately, req_ready 1, no resp_valid.
- Macro on: LHU at addr 0x7, words 0xAA00_0000 and 0x0000_00BB -> two reads (addr 0x1 be 1000, addr 0x2 be 0001), resp_rdata 0x0000_BBAA.
